// File: rtl/ofs_plat_local_mem_avalon_responder.sv
// ofs_plat_local_mem_avalon_responder
//   Avalon-MM burst responder backed by a local line-addressed memory.
//   Writes are accepted beat by beat (bubbles allowed). Reads are accepted in
//   IDLE and then stall the command bus while one line per cycle is issued;
//   each issued line returns on readdatavalid READ_LATENCY cycles later.
//   Optional protocol checking is enabled by defining
//   OFS_PLAT_LOCAL_MEM_AVALON_RESPONDER_CHECK_EN; without it, error is tied low.
module ofs_plat_local_mem_avalon_responder #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       waitrequest,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH-1:0]      writedata,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid,
  output logic                       error
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int MEM_LINES = 1 << MEM_DEPTH_LOG2;

  localparam logic [MEM_DEPTH_LOG2-1:0]  LINE_ONE = MEM_DEPTH_LOG2'(1);
  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE   = BURST_CNT_WIDTH'(1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_BURST = 2'd1;
  localparam logic [1:0] ST_RD_BURST = 2'd2;

  logic [1:0]                 r_state;
  logic [MEM_DEPTH_LOG2-1:0]  r_line;       // next line to write or issue
  logic [BURST_CNT_WIDTH-1:0] r_remaining;  // beats still to write or issue
  logic [DATA_WIDTH-1:0]      r_mem [MEM_LINES];

  logic [READ_LATENCY-1:0]    r_pipe_vld;
  logic [DATA_WIDTH-1:0]      r_pipe_data [READ_LATENCY];

  logic                       w_idle;
  logic                       w_wr_accept;
  logic                       w_rd_accept;
  logic                       w_wr_beat;
  logic                       w_rd_issue;
  logic [BURST_CNT_WIDTH-1:0] w_bc_eff;
  logic [MEM_DEPTH_LOG2-1:0]  w_cmd_line;
  logic [MEM_DEPTH_LOG2-1:0]  w_wr_line;

  // Upper address bits select nothing: lines wrap modulo the memory depth.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, address[ADDR_WIDTH-1:MEM_DEPTH_LOG2]};

  assign w_idle      = (r_state == ST_IDLE);
  assign w_cmd_line  = address[MEM_DEPTH_LOG2-1:0];
  assign w_bc_eff    = (burstcount == '0) ? BC_ONE : burstcount;

  // Write has priority over a simultaneous read in IDLE.
  assign w_wr_accept = w_idle & write & ~reset;
  assign w_rd_accept = w_idle & read & ~write & ~reset;
  assign w_wr_beat   = w_wr_accept | ((r_state == ST_WR_BURST) & write & ~reset);
  assign w_wr_line   = w_idle ? w_cmd_line : r_line;
  assign w_rd_issue  = (r_state == ST_RD_BURST) & ~reset;

  assign waitrequest   = reset | (r_state == ST_RD_BURST);
  assign readdata      = r_pipe_data[READ_LATENCY-1];
  assign readdatavalid = r_pipe_vld[READ_LATENCY-1];

  // Burst sequencing: tracks current line and beats left for the active burst.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state     <= ST_IDLE;
      r_line      <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_accept) begin
            // First beat is written now; the rest follow from r_line.
            r_line      <= w_cmd_line + LINE_ONE;
            r_remaining <= w_bc_eff - BC_ONE;
            if (w_bc_eff != BC_ONE) r_state <= ST_WR_BURST;
          end else if (w_rd_accept) begin
            r_line      <= w_cmd_line;
            r_remaining <= w_bc_eff;
            r_state     <= ST_RD_BURST;
          end
        end
        ST_WR_BURST: begin
          if (write) begin
            r_line      <= r_line + LINE_ONE;
            r_remaining <= r_remaining - BC_ONE;
            if (r_remaining == BC_ONE) r_state <= ST_IDLE;
          end
        end
        ST_RD_BURST: begin
          r_line      <= r_line + LINE_ONE;
          r_remaining <= r_remaining - BC_ONE;
          if (r_remaining == BC_ONE) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Backing store: byte-masked write of each accepted write beat.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset; contents survive
    // reset and the array can map onto block RAM.
    if (w_wr_beat) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (byteenable[b]) r_mem[w_wr_line][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // Read return pipeline: stage 0 samples the array at issue; data stages
  // only load on a valid beat so readdata holds between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) r_pipe_data[k] <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_issue;
      if (w_rd_issue) r_pipe_data[0] <= r_mem[r_line];
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) r_pipe_data[k] <= r_pipe_data[k-1];
      end
    end
  end

`ifdef OFS_PLAT_LOCAL_MEM_AVALON_RESPONDER_CHECK_EN
  localparam logic [BURST_CNT_WIDTH-1:0] MAX_BURST =
    BURST_CNT_WIDTH'(1) << (BURST_CNT_WIDTH - 1);

  logic r_error;
  logic w_accept;
  logic w_bc_bad;
  logic w_violation;

  assign w_accept    = w_idle & (read | write);
  assign w_bc_bad    = (burstcount == '0) || (burstcount > MAX_BURST);
  assign w_violation = (w_accept & w_bc_bad)
                     | (w_idle & read & write)
                     | ((r_state == ST_WR_BURST) & read);

  // Sticky protocol-error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)            r_error <= 1'b0;
    else if (w_violation) r_error <= 1'b1;
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ofs_plat_local_mem_avalon_responder.sv
// Testbench for ofs_plat_local_mem_avalon_responder.
// Directed write/read bursts; expected read beats (data and arrival cycle) are
// queued when a read is issued and a separate monitor pops them whenever
// readdatavalid is seen. Works with or without
// OFS_PLAT_LOCAL_MEM_AVALON_RESPONDER_CHECK_EN.
module tb_ofs_plat_local_mem_avalon_responder;

  localparam int AW  = 27;
  localparam int DW  = 512;
  localparam int BCW = 7;
  localparam int MDL = 10;
  localparam int LAT = 2;

`ifdef OFS_PLAT_LOCAL_MEM_AVALON_RESPONDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            waitrequest;
  logic            read;
  logic            write;
  logic [AW-1:0]   address;
  logic [BCW-1:0]  burstcount;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic            error;

  ofs_plat_local_mem_avalon_responder #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BURST_CNT_WIDTH (BCW),
    .MEM_DEPTH_LOG2  (MDL),
    .READ_LATENCY    (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .waitrequest   (waitrequest),
    .read          (read),
    .write         (write),
    .address       (address),
    .burstcount    (burstcount),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            cycle;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_beats [8];
  logic          exp_err;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every readdatavalid beat must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (readdatavalid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_readdatavalid", DW'(readdatavalid), '0);
        end else begin
          e = exp_q.pop_front();
          check("rd_beat_data", readdata, e.data);
          check("rd_beat_cycle", DW'(cyc), DW'(e.cycle));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    burstcount = '0;
    writedata  = '0;
    byteenable = '0;
  endtask

  // Write burst; beat i carries base+i. Later beats drive junk address and
  // burstcount. A bubble is inserted before beat bubble_at (-1: none).
  // with_read holds read high alongside every write beat.
  task automatic wr_burst(input logic [AW-1:0] addr, input logic [BCW-1:0] bc,
                          input int nbeats, input logic [DW-1:0] base,
                          input logic [DW/8-1:0] be, input int bubble_at,
                          input logic with_read);
    for (int i = 0; i < nbeats; i++) begin
      if (i == bubble_at) begin
        write = 1'b0;
        read  = 1'b0;
        tick();
      end
      write      = 1'b1;
      read       = with_read;
      address    = (i == 0) ? addr : {AW{1'b1}};
      burstcount = (i == 0) ? bc : BCW'(1);
      writedata  = base + DW'(i);
      byteenable = be;
      tick();
    end
    idle_inputs();
  endtask

  // Read burst expecting exp_beats[0..n-1]; checks waitrequest duration and
  // that readdata holds its last value afterwards.
  task automatic rd_burst(input logic [AW-1:0] addr, input logic [BCW-1:0] bc,
                          input int n);
    int a;
    int w;
    exp_t e;
    check("rd_waitreq_low_before", DW'(waitrequest), '0);
    read       = 1'b1;
    address    = addr;
    burstcount = bc;
    a = cyc;
    for (int i = 0; i < n; i++) begin
      e.data  = exp_beats[i];
      e.cycle = a + 1 + i + LAT;
      exp_q.push_back(e);
    end
    tick();
    idle_inputs();
    w = 0;
    while (waitrequest === 1'b1 && w < 64) begin
      w++;
      tick();
    end
    check("rd_waitreq_cycles", DW'(w), DW'(n));
    repeat (LAT + 2) tick();
    check("rd_hold_readdata", readdata, exp_beats[n-1]);
    check("rd_valid_low_after", DW'(readdatavalid), '0);
  endtask

  initial begin
    int t;
    idle_inputs();
    exp_err = 1'b0;
    reset   = 1'b1;
    repeat (3) tick();
    check("reset_waitrequest", DW'(waitrequest), DW'(1));
    check("reset_readdatavalid", DW'(readdatavalid), '0);
    check("reset_readdata", readdata, '0);
    check("reset_error", DW'(error), '0);
    reset = 1'b0;
    #1;
    check("post_reset_waitrequest", DW'(waitrequest), '0);
    tick();

    // 4-beat write then read back at line 0x10.
    wr_burst(27'h10, 7'd4, 4, DW'('hA0), '1, -1, 1'b0);
    for (int i = 0; i < 4; i++) exp_beats[i] = DW'('hA0 + i);
    rd_burst(27'h10, 7'd4, 4);
    check("error_clean_traffic", DW'(error), DW'(exp_err));

    // Byte-masked overwrite of line 5.
    wr_burst(27'h5, 7'd1, 1, '1, '1, -1, 1'b0);
    wr_burst(27'h5, 7'd1, 1, '0, DW'(1), -1, 1'b0);
    exp_beats[0] = {{(DW-8){1'b1}}, 8'h00};
    rd_burst(27'h5, 7'd1, 1);

    // Wrapping write burst with a bubble, then wrapped/aliased reads.
    wr_burst(27'h3FE, 7'd4, 4, DW'('hB0), '1, 2, 1'b0);
    exp_beats[0] = DW'('hB2);
    rd_burst(27'h400, 7'd1, 1);
    for (int i = 0; i < 4; i++) exp_beats[i] = DW'('hB0 + i);
    rd_burst(27'h3FE, 7'd4, 4);
    exp_beats[0] = DW'('hB3);
    rd_burst(27'h7FF_FC01, 7'd1, 1);

    // burstcount 0 acts as 1 for both write and read.
    wr_burst(27'h7, 7'd0, 1, DW'('hC7), '1, -1, 1'b0);
    exp_err = CHK;
    exp_beats[0] = DW'('hC7);
    rd_burst(27'h7, 7'd0, 1);
    check("error_after_bc0", DW'(error), DW'(exp_err));

    // Read and write together in IDLE: write wins, read dropped.
    wr_burst(27'h9, 7'd1, 1, DW'('hD9), '1, -1, 1'b1);
    exp_err = CHK;
    repeat (LAT + 3) tick();
    check("error_after_rw_together", DW'(error), DW'(exp_err));
    exp_beats[0] = DW'('hD9);
    rd_burst(27'h9, 7'd1, 1);

    // Read held high through a 2-beat write burst is ignored.
    wr_burst(27'h20, 7'd2, 2, DW'('hE0), '1, -1, 1'b1);
    repeat (LAT + 3) tick();
    exp_beats[0] = DW'('hE0);
    exp_beats[1] = DW'('hE1);
    rd_burst(27'h20, 7'd2, 2);
    check("error_sticky", DW'(error), DW'(exp_err));

    // Reset one cycle after accepting an 8-beat read: burst abandoned.
    read       = 1'b1;
    address    = 27'h10;
    burstcount = 7'd8;
    tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    check("midburst_reset_waitrequest", DW'(waitrequest), DW'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midburst_reset_valid_low", DW'(readdatavalid), '0);
    end
    check("midburst_reset_error", DW'(error), '0);
    reset = 1'b0;
    #1;
    check("midburst_post_reset_waitrequest", DW'(waitrequest), '0);
    exp_err = 1'b0;
    repeat (12) tick();
    check("midburst_readdata_cleared", readdata, '0);
    check("midburst_waitrequest_idle", DW'(waitrequest), '0);

    // Backing store survives reset.
    for (int i = 0; i < 4; i++) exp_beats[i] = DW'('hA0 + i);
    rd_burst(27'h10, 7'd4, 4);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      t++;
      tick();
    end
    check("scoreboard_drained", DW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ofs_plat_local_mem_avalon_responder.md
OFS_PLAT_LOCAL_MEM_AVALON_RESPONDER -- requirements
Module: ofs_plat_local_mem_avalon_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, line-index address width (no byte offset).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, data bus width; a multiple of 8.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 7, burstcount width; maximum legal burst is 2^(BURST_CNT_WIDTH-1).
REQ-004 SHALL have parameter MEM_DEPTH_LOG2, default 10, log2 of backing-store lines; at most ADDR_WIDTH.
REQ-005 SHALL have parameter READ_LATENCY, default 2, cycles from read-beat issue to readdatavalid; at least 1.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port waitrequest, output, 1, command backpressure.
REQ-009 SHALL have ports read and write, input, 1 each, command strobes.
REQ-010 SHALL have port address, input, ADDR_WIDTH, burst start line.
REQ-011 SHALL have port burstcount, input, BURST_CNT_WIDTH, beats in the burst.
REQ-012 SHALL have ports writedata (input, DATA_WIDTH) and byteenable (input, DATA_WIDTH/8), write beat data and byte mask.
REQ-013 SHALL have ports readdata (output, DATA_WIDTH) and readdatavalid (output, 1), read response beat.
REQ-014 SHALL have port error, output, 1, sticky protocol-error flag.

Function
REQ-015 SHALL implement a state machine with states IDLE, WR_BURST, RD_BURST.
REQ-016 SHALL drive waitrequest high in RD_BURST and during reset, low otherwise.
REQ-017 SHALL accept a command in IDLE when read or write is high and waitrequest is low.
REQ-018 SHALL, on write acceptance, latch address as base and burstcount as remaining; burstcount 0 is treated as 1.
REQ-019 SHALL write each accepted write beat i to line (base+i) mod 2^MEM_DEPTH_LOG2, updating only bytes whose byteenable bit is 1.
REQ-020 SHALL ignore address and burstcount on write beats after the first.
REQ-021 SHALL enter WR_BURST after the first beat of a burst longer than 1, stay there until the last beat is accepted, then return to IDLE; a 1-beat burst stays in IDLE.
REQ-022 SHALL, in WR_BURST, not advance on cycles where write is low (master may insert bubbles).
REQ-023 SHALL, on read acceptance, latch base and burstcount (0 treated as 1), enter RD_BURST on the next cycle, and issue one read beat per cycle starting with line base at acceptance.
REQ-024 SHALL return to IDLE on the cycle after the last read beat issues; waitrequest falls in that cycle.
REQ-025 SHALL assert readdatavalid with the issued line's data exactly READ_LATENCY cycles after each issue, in order, with no gaps within a burst.
REQ-026 SHALL sample the array at issue time; a read issued on the cycle after a write beat observes that write.
REQ-027 SHALL wrap line addresses modulo 2^MEM_DEPTH_LOG2; upper address bits are ignored.
REQ-028 SHALL give write priority when read and write are both high in IDLE; the read is dropped.
REQ-029 SHALL ignore read asserted during WR_BURST.
REQ-030 SHALL hold readdata at its last value when readdatavalid is low.

Reset
REQ-031 SHALL, while reset is high, force state IDLE, waitrequest 1, readdatavalid 0, readdata 0, error 0, and flush the read pipeline.
REQ-032 SHALL abandon an in-flight burst when reset asserts mid-burst; no further readdatavalid beats from it.
REQ-033 SHALL NOT clear backing-store contents on reset.

Configuration
REQ-034 SHALL honour macro OFS_PLAT_LOCAL_MEM_AVALON_RESPONDER_CHECK_EN.
REQ-035 SHALL, with the macro defined, set error sticky high (cleared only by reset) on: burstcount 0 at acceptance, burstcount above 2^(BURST_CNT_WIDTH-1), read and write together in IDLE, or read high in WR_BURST.
REQ-036 SHALL, without the macro, tie error to 0 and include no checking logic; all other behaviour is identical.

Verification
REQ-037 SHALL cover: write burst addr 0x10, burstcount 4, data 0xA0..0xA3, byteenable all-ones; then read addr 0x10, burstcount 4 -> four readdatavalid beats 0xA0..0xA3 starting 2 cycles after issue, waitrequest high 4 cycles.
REQ-038 SHALL cover: write 0xFFFF..FF to line 5, then write 0x00 to line 5 with byteenable 0x1 -> read line 5 returns all-ones except byte 0 = 0x00.
REQ-039 SHALL cover: MEM_DEPTH_LOG2=10, write burst addr 0x3FE, burstcount 4 -> lines 0x3FE, 0x3FF, 0x000, 0x001 written; read addr 0x400 returns the third beat.
REQ-040 SHALL cover: reset asserted 1 cycle after read acceptance of burstcount 8 -> no readdatavalid after reset, waitrequest 1 during reset, 0 the cycle after reset deasserts.
REQ-041 SHALL cover: with OFS_PLAT_LOCAL_MEM_AVALON_RESPONDER_CHECK_EN, read and write high together in IDLE -> write performed, no read beats, error 1 until reset; without the macro, error stays 0.
